fp_align: RTL and testbench

Pre-add operand alignment unit for the single-precision FP datapath, the counterpart to post-add normalization. Given two operands, it selects the one with the larger exponent and shifts the smaller operand's significand right until the exponents match, preserving guard/round/sticky bits. It sits between operand unpack and the significand adder, behind a start/done handshake. By default it shifts iteratively, one bit per cycle.

---
 rtl/fp_align.sv | 176 +++++++++++++++++
 tb/tb_fp_align.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_align.sv
// fp_align -- pre-add operand alignment for the single-precision FP datapath.
//
// Picks the operand with the larger exponent and right-shifts the other
// operand's significand until both exponents match. Bits shifted past the
// round position are collected in a sticky bit. A start/done handshake
// frames each operation.
//
// Configuration macro: FP_ALIGN_BARREL_EN
//   undefined : iterative alignment, one bit per cycle (latency d+1 edges)
//   defined   : whole shift on one edge with a barrel shifter (latency 2)
//   Both builds produce bit-identical results.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   start            request, sampled only while busy=0
//   expA/fracA       operand A exponent / fraction
//   expB/fracB       operand B exponent / fraction
//   busy             alignment in progress
//   done             one-cycle pulse, outputs valid from this cycle
//   swapped          1 = B had the larger exponent
//   expOut           common (larger) exponent
//   fracBig          {hidden, frac, 3'b000} of the larger operand
//   fracSmall        aligned smaller significand {hidden, frac, G, R, S}

module fp_align #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 23,
    localparam int unsigned SIG_W = FRAC_W + 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [EXP_W-1:0]  expA,
    input  logic [FRAC_W-1:0] fracA,
    input  logic [EXP_W-1:0]  expB,
    input  logic [FRAC_W-1:0] fracB,
    output logic              busy,
    output logic              done,
    output logic              swapped,
    output logic [EXP_W-1:0]  expOut,
    output logic [SIG_W-1:0]  fracBig,
    output logic [SIG_W-1:0]  fracSmall
);

    // Beyond SIG_W-1 shifts every original bit already sits in S.
    localparam int unsigned MAX_SHIFT = SIG_W - 1;
    localparam int unsigned CNT_W     = $clog2(SIG_W);

    typedef enum logic {
        IDLE,
        ALIGN
    } state_t;

    state_t             state_q;
    logic               busy_q;
    logic               done_q;
    logic               swapped_q;
    logic [EXP_W-1:0]   exp_q;
    logic [SIG_W-1:0]   big_q;
    logic [SIG_W-1:0]   small_q;
    logic [CNT_W-1:0]   cnt_q;

    // Operand selection for an accepted start.
    logic               swap_d;
    logic [EXP_W-1:0]   diff_d;
    logic [EXP_W-1:0]   exp_d;
    logic [SIG_W-1:0]   sig_a_d;
    logic [SIG_W-1:0]   sig_b_d;
    logic [SIG_W-1:0]   big_d;
    logic [SIG_W-1:0]   small_d;
    logic [CNT_W-1:0]   cnt_d;

    always_comb begin
        sig_a_d = {(|expA), fracA, 3'b000};
        sig_b_d = {(|expB), fracB, 3'b000};
        swap_d  = (expB > expA);
        diff_d  = swap_d ? (expB - expA) : (expA - expB);
        exp_d   = swap_d ? expB : expA;
        big_d   = swap_d ? sig_b_d : sig_a_d;
        small_d = swap_d ? sig_a_d : sig_b_d;
        if (diff_d > EXP_W'(MAX_SHIFT)) begin
            cnt_d = CNT_W'(MAX_SHIFT);
        end else begin
            cnt_d = diff_d[CNT_W-1:0];
        end
    end

`ifdef FP_ALIGN_BARREL_EN
    // Bits [SIG_W-1:1] shift right by cnt; everything pushed below bit 1
    // joins the existing sticky bit.
    logic [SIG_W-2:0] upper;
    logic [SIG_W-2:0] ones;
    logic [SIG_W-2:0] lost;
    logic [SIG_W-1:0] shift_d;
    logic             shifted_q;

    always_comb begin
        upper   = small_q[SIG_W-1:1];
        ones    = '1;
        lost    = upper & ~(ones << cnt_q);
        shift_d = {upper >> cnt_q, small_q[0] | (|lost)};
    end
`else
    logic [SIG_W-1:0] shift_d;

    always_comb begin
        shift_d = {1'b0, small_q[SIG_W-1:2], small_q[1] | small_q[0]};
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            swapped_q <= 1'b0;
            exp_q     <= '0;
            big_q     <= '0;
            small_q   <= '0;
            cnt_q     <= '0;
`ifdef FP_ALIGN_BARREL_EN
            shifted_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        swapped_q <= swap_d;
                        exp_q     <= exp_d;
                        big_q     <= big_d;
                        small_q   <= small_d;
                        cnt_q     <= cnt_d;
                        busy_q    <= 1'b1;
                        state_q   <= ALIGN;
`ifdef FP_ALIGN_BARREL_EN
                        shifted_q <= 1'b0;
`endif
                    end
                end
                ALIGN: begin
`ifdef FP_ALIGN_BARREL_EN
                    // First ALIGN cycle shifts (even by zero), second finishes.
                    if (!shifted_q) begin
                        small_q   <= shift_d;
                        cnt_q     <= '0;
                        shifted_q <= 1'b1;
                    end else begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
`else
                    if (cnt_q != '0) begin
                        small_q <= shift_d;
                        cnt_q   <= cnt_q - 1'b1;
                    end else begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign swapped   = swapped_q;
    assign expOut    = exp_q;
    assign fracBig   = big_q;
    assign fracSmall = small_q;

endmodule

// File: tb/tb_fp_align.sv
module tb_fp_align;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  expA, expB;
    logic [22:0] fracA, fracB;
    logic        busy, done, swapped;
    logic [7:0]  expOut;
    logic [26:0] fracBig, fracSmall;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fp_align #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk(clk), .rst(rst), .start(start),
        .expA(expA), .fracA(fracA), .expB(expB), .fracB(fracB),
        .busy(busy), .done(done), .swapped(swapped),
        .expOut(expOut), .fracBig(fracBig), .fracSmall(fracSmall)
    );

    // Reference: exact right shift of the smaller significand by the true
    // (unclamped) exponent difference, with every lost bit folded into bit 0.
    function automatic void model(input logic [7:0] ea, input logic [22:0] fa,
                                  input logic [7:0] eb, input logic [22:0] fb,
                                  output logic sw, output logic [7:0] eo,
                                  output logic [26:0] big, output logic [26:0] sml,
                                  output int lat);
        longint sa, sb, s, r;
        int diff, d;
        sa = (longint'(ea != 0) << 26) + (longint'(fa) << 3);
        sb = (longint'(eb != 0) << 26) + (longint'(fb) << 3);
        sw = (eb > ea);
        diff = sw ? (int'(eb) - int'(ea)) : (int'(ea) - int'(eb));
        eo  = sw ? eb : ea;
        big = sw ? 27'(sb) : 27'(sa);
        s   = sw ? sa : sb;
        if (diff >= 60) r = (s != 0) ? 1 : 0;
        else begin
            r = s >> diff;
            if ((s % (longint'(1) << diff)) != 0) r = r | 1;
        end
        sml = 27'(r);
        d = (diff > 26) ? 26 : diff;
`ifdef FP_ALIGN_BARREL_EN
        lat = 2;
`else
        lat = d + 1;
`endif
    endfunction

    // Issues one operation; reports edges from E0 to the done cycle (-1 on
    // timeout) and whether busy misbehaved while waiting.
    task automatic do_op(input logic [7:0] ea, input logic [22:0] fa,
                         input logic [7:0] eb, input logic [22:0] fb,
                         output int lat, output logic busy_bad);
        int n;
        busy_bad = 1'b0;
        lat = -1;
        expA = ea; fracA = fa; expB = eb; fracB = fb; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        expA = 8'($urandom); fracA = 23'($urandom);
        expB = 8'($urandom); fracB = 23'($urandom);
        for (n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                if (busy) busy_bad = 1'b1;
                lat = n;
                break;
            end
            if (!busy) busy_bad = 1'b1;
        end
    endtask

    task automatic check_op(input string name, input logic [7:0] ea, input logic [22:0] fa,
                            input logic [7:0] eb, input logic [22:0] fb);
        logic sw; logic [7:0] eo; logic [26:0] big, sml; int elat, lat; logic bb;
        model(ea, fa, eb, fb, sw, eo, big, sml, elat);
        do_op(ea, fa, eb, fb, lat, bb);
        n_checks++;
        if (lat !== elat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, elat);
        end
        n_checks++;
        if (bb !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy: got bad=%0b expected 0", name, bb);
        end
        n_checks++;
        if ({swapped, expOut, fracBig, fracSmall} !== {sw, eo, big, sml}) begin
            n_fail++;
            $display("FAIL %s result: got sw=%0b exp=%0d big=%h small=%h expected sw=%0b exp=%0d big=%h small=%h (A=%0d/%h B=%0d/%h)",
                     name, swapped, expOut, fracBig, fracSmall, sw, eo, big, sml, ea, fa, eb, fb);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        expA = '0; fracA = '0; expB = '0; fracB = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({busy, done, swapped, expOut, fracBig, fracSmall} !== '0) begin
            n_fail++;
            $display("FAIL reset: got busy=%0b done=%0b sw=%0b exp=%0d big=%h small=%h expected all 0",
                     busy, done, swapped, expOut, fracBig, fracSmall);
        end
    endtask

    task automatic test_directed();
        logic sw; logic [7:0] eo; logic [26:0] big, sml; int elat;
        // Hand-derived expectations anchor the model itself.
        model(8'd200, 23'h0, 8'd100, 23'h1, sw, eo, big, sml, elat);
        n_checks++;
        if (sml !== 27'h0000001 || big !== 27'h4000000) begin
            n_fail++;
            $display("FAIL model_clamp: got small=%h big=%h expected 0000001/4000000", sml, big);
        end
        check_op("case1", 8'd130, 23'h400000, 8'd128, 23'h0);
        n_checks++;
        if (fracBig !== 27'h6000000 || fracSmall !== 27'h1000000) begin
            n_fail++;
            $display("FAIL case1_const: got big=%h small=%h expected 6000000/1000000", fracBig, fracSmall);
        end
        check_op("case2", 8'd127, 23'h0, 8'd129, 23'h0);
        n_checks++;
        if (swapped !== 1'b1 || fracSmall !== 27'h1000000) begin
            n_fail++;
            $display("FAIL case2_const: got sw=%0b small=%h expected 1/1000000", swapped, fracSmall);
        end
        check_op("case3", 8'd100, 23'h123456, 8'd100, 23'h7FFFFF);
        n_checks++;
        if (fracSmall !== 27'h7FFFFF8 || swapped !== 1'b0) begin
            n_fail++;
            $display("FAIL case3_const: got sw=%0b small=%h expected 0/7fffff8", swapped, fracSmall);
        end
        check_op("case4", 8'd200, 23'h0, 8'd100, 23'h1);
        check_op("diff27", 8'd27, 23'h7FFFFF, 8'd0, 23'h7FFFFF);
        check_op("denorm", 8'd0, 23'h2AAAAA, 8'd3, 23'h155555);
        check_op("maxexp", 8'd255, 23'h7FFFFF, 8'd1, 23'h0);
    endtask

    task automatic test_abort();
        int seen;
        expA = 8'd130; fracA = 23'h400000; expB = 8'd128; fracB = 23'h0; start = 1'b1;
        @(posedge clk);                      // E0 accepted
        @(negedge clk);
        expA = 8'd10; fracA = 23'h1; expB = 8'd50; fracB = 23'h2;   // ignored at E1
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (swapped !== 1'b0 || expOut !== 8'd130 || fracBig !== 27'h6000000 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_start: got sw=%0b exp=%0d big=%h busy=%0b expected 0/130/6000000/1",
                     swapped, expOut, fracBig, busy);
        end
        start = 1'b0; rst = 1'b1;
        @(posedge clk);                      // E2 reset
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({busy, done, swapped, expOut, fracBig, fracSmall} !== '0) begin
            n_fail++;
            $display("FAIL abort_reset: got busy=%0b done=%0b sw=%0b exp=%0d big=%h small=%h expected all 0",
                     busy, done, swapped, expOut, fracBig, fracSmall);
        end
        seen = 0;
        repeat (32) begin
            @(posedge clk);
            @(negedge clk);
            if (done || busy) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d active cycles expected 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ea, eb; logic [22:0] fa, fb;
        for (int i = 0; i < 60; i++) begin
            ea = 8'($urandom); eb = 8'($urandom);
            fa = 23'($urandom); fb = 23'($urandom);
            case (i % 5)
                0: eb = ea;
                1: eb = 8'(ea + 8'($urandom_range(1, 5)));
                2: ea = 8'($urandom_range(0, 2));
                3: fb = 23'($urandom_range(0, 3));
                default: ;
            endcase
            check_op("random", ea, fa, eb, fb);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
